// File: rtl/frame_compositor.sv
// frame_compositor: latches the game state once per frame and composites
// player/enemy sprites, shield rings, bullets and HP boxes over a background
// (or a state banner) in a fixed 3-stage pipeline, one RGB value per pixel.

// Per-object hit test: box hit, squat lower-half clip and the shield ring.
module fc_obj_hit #(
   parameter int W = 64,
   parameter int H = 96
) (
   input  logic [10:0] pix_x,
   input  logic [9:0]  pix_y,
   input  logic [10:0] obj_x,    // signed top-left x
   input  logic [9:0]  obj_y,    // signed top-left y
   input  logic        en,
   input  logic        squat,
   input  logic        ring_en,
   output logic        hit,
   output logic        ring
);
   localparam logic signed [11:0] ZERO   = 12'sd0;
   localparam logic signed [11:0] NEG2   = -12'sd2;
   localparam logic signed [11:0] W_L    = 12'(W);
   localparam logic signed [11:0] H_L    = 12'(H);
   localparam logic signed [11:0] HALF_H = 12'(H / 2);
   localparam logic signed [11:0] W_RING = 12'(W + 2);
   localparam logic signed [11:0] H_RING = 12'(H + 2);

   logic signed [11:0] dx, dy;
   logic               in_box, in_outer;

   // 12-bit signed offsets so objects hanging off any edge clip cleanly
   assign dx       = $signed({1'b0, pix_x}) - $signed({obj_x[10], obj_x});
   assign dy       = $signed({2'b00, pix_y}) - $signed({{2{obj_y[9]}}, obj_y});
   assign in_box   = (dx >= ZERO) && (dx < W_L) && (dy >= ZERO) && (dy < H_L);
   assign in_outer = (dx >= NEG2) && (dx < W_RING) && (dy >= NEG2) && (dy < H_RING);
   // squat keeps only the lower half of the box
   assign hit      = en && in_box && (!squat || (dy >= HALF_H));
   // the ring never covers the box itself, squatting or not
   assign ring     = ring_en && in_outer && !in_box;
endmodule

module frame_compositor #(
   parameter int SPR_W     = 64,
   parameter int SPR_H     = 96,
   parameter int BUL_SZ    = 16,
   parameter int HP_BOX    = 24,
   parameter int BLINK_BIT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_frame_start,
   input  logic        i_pix_valid,
   input  logic [10:0] i_pix_x,
   input  logic [9:0]  i_pix_y,
   input  logic [1:0]  i_state,
   input  logic [10:0] i_player_x,
   input  logic [10:0] i_enemy_x,
   input  logic [10:0] i_goodbullet_x,
   input  logic [10:0] i_badbullet_x,
   input  logic [9:0]  i_player_y,
   input  logic [9:0]  i_enemy_y,
   input  logic [9:0]  i_goodbullet_y,
   input  logic [9:0]  i_badbullet_y,
   input  logic [1:0]  i_player_hp,
   input  logic [1:0]  i_enemy_hp,
   input  logic        i_player_shield,
   input  logic        i_enemy_shield,
   input  logic        i_player_squat,
   input  logic        i_enemy_squat,
   input  logic        i_goodbullet_isE,
   input  logic        i_badbullet_isE,
   output logic [23:0] o_rgb,
   output logic        o_rgb_valid,
   output logic [7:0]  o_frame_cnt
);
   localparam int NUM_OBJ = 4;    // lanes: 0 player, 1 enemy, 2 good bullet, 3 bad bullet
   localparam int STAGES  = 3;
   localparam int SCR_W   = 640;
   localparam int MAX_HP  = 3;

   typedef enum logic [1:0] {ST_START = 2'b00, ST_PLAY = 2'b01, ST_WIN = 2'b10, ST_LOSE = 2'b11} game_state_t;

   typedef enum logic [3:0] {
      L_BG, L_HP, L_ENEMY, L_PLAYER, L_RING, L_GOOD, L_BAD,
      L_BLACK, L_BAND_START, L_BAND_WIN, L_BAND_LOSE
   } layer_t;

   typedef struct packed {
      game_state_t              state;
      logic [NUM_OBJ-1:0][10:0] x;
      logic [NUM_OBJ-1:0][9:0]  y;
      logic [1:0]               php;
      logic [1:0]               ehp;
      logic [1:0]               shield;   // [0] player, [1] enemy
      logic [1:0]               squat;    // [0] player, [1] enemy
      logic [1:0]               bul_e;    // [0] good, [1] bad
   } snap_t;

   typedef struct packed {
      game_state_t        state;
      logic               band;
      logic               hp;
      logic [NUM_OBJ-1:0] hit;
      logic [NUM_OBJ-1:0] ring;
   } s1_t;

   snap_t              snap, snap_nxt;
   s1_t                s1_d, s1_q;
   layer_t             layer, s2_q;
   logic [STAGES:1]    vld_pipe;
   logic [23:0]        rgb_sel;
   logic [NUM_OBJ-1:0] obj_en, obj_sq, obj_ring_en, obj_hit, obj_ring;
   logic [MAX_HP-1:0]  hp_box;
   logic               hp_row;

   // Next snapshot, assembled straight from the live game inputs
   always_comb begin
      snap_nxt        = '0;
      snap_nxt.state  = game_state_t'(i_state);
      snap_nxt.x      = {i_badbullet_x, i_goodbullet_x, i_enemy_x, i_player_x};
      snap_nxt.y      = {i_badbullet_y, i_goodbullet_y, i_enemy_y, i_player_y};
      snap_nxt.php    = i_player_hp;
      snap_nxt.ehp    = i_enemy_hp;
      snap_nxt.shield = {i_enemy_shield, i_player_shield};
      snap_nxt.squat  = {i_enemy_squat, i_player_squat};
      snap_nxt.bul_e  = {i_badbullet_isE, i_goodbullet_isE};
   end

   // Snapshot and frame counter move together on the frame-start edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap        <= '0;
         snap.php    <= 2'd3;
         snap.ehp    <= 2'd3;
         o_frame_cnt <= '0;
      end else if (i_frame_start) begin
         snap        <= snap_nxt;
         o_frame_cnt <= o_frame_cnt + 8'd1;
      end
   end

   assign obj_en      = {snap.bul_e, 2'b11};
   assign obj_sq      = {2'b00, snap.squat};
   assign obj_ring_en = {2'b00, snap.shield & {2{o_frame_cnt[BLINK_BIT]}}};

   for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
      localparam int OW = (g < 2) ? SPR_W : BUL_SZ;
      localparam int OH = (g < 2) ? SPR_H : BUL_SZ;
      fc_obj_hit #(.W(OW), .H(OH)) u_hit (
         .pix_x   (i_pix_x),
         .pix_y   (i_pix_y),
         .obj_x   (snap.x[g]),
         .obj_y   (snap.y[g]),
         .en      (obj_en[g]),
         .squat   (obj_sq[g]),
         .ring_en (obj_ring_en[g]),
         .hit     (obj_hit[g]),
         .ring    (obj_ring[g])
      );
   end

   // HP boxes: player from the left edge, enemy mirrored from the right edge
   assign hp_row = (i_pix_y >= 10'd8) && (i_pix_y < 10'(8 + HP_BOX));
   for (genvar b = 0; b < MAX_HP; b++) begin : g_hp
      localparam logic [10:0] PX0 = 11'(8 + 2 * HP_BOX * b);
      localparam logic [10:0] EX0 = 11'(SCR_W - 8 - HP_BOX - 2 * HP_BOX * b);
      localparam logic [10:0] BOX = 11'(HP_BOX);
      assign hp_box[b] = ((i_pix_x >= PX0) && (i_pix_x < PX0 + BOX) && (snap.php > 2'(b))) ||
                         ((i_pix_x >= EX0) && (i_pix_x < EX0 + BOX) && (snap.ehp > 2'(b)));
   end

   // S1 payload: everything later stages need, frozen under this pixel's snapshot
   always_comb begin
      s1_d       = '0;
      s1_d.state = snap.state;
      s1_d.band  = (i_pix_y >= 10'd200) && (i_pix_y <= 10'd279);
      s1_d.hp    = hp_row && (|hp_box);
      s1_d.hit   = obj_hit;
      s1_d.ring  = obj_ring;
   end

   // S2 layer pick: later assignments win, so this reads lowest to highest priority
   always_comb begin
      layer = L_BG;
      if (s1_q.hp)      layer = L_HP;
      if (s1_q.hit[1])  layer = L_ENEMY;
      if (s1_q.ring[1]) layer = L_RING;
      if (s1_q.hit[0])  layer = L_PLAYER;
      if (s1_q.ring[0]) layer = L_RING;
      if (s1_q.hit[2])  layer = L_GOOD;
      if (s1_q.ring[2]) layer = L_RING;
      if (s1_q.hit[3])  layer = L_BAD;
      if (s1_q.ring[3]) layer = L_RING;
      if (s1_q.state != ST_PLAY) begin
         if (!s1_q.band)                   layer = L_BLACK;
         else if (s1_q.state == ST_WIN)    layer = L_BAND_WIN;
         else if (s1_q.state == ST_LOSE)   layer = L_BAND_LOSE;
         else                              layer = L_BAND_START;
      end
   end

   // S3 colour lookup
   always_comb begin
      rgb_sel = 24'h202040;
      case (s2_q)
         L_BG:         rgb_sel = 24'h202040;
         L_HP:         rgb_sel = 24'hE00000;
         L_ENEMY:      rgb_sel = 24'hFF6030;
         L_PLAYER:     rgb_sel = 24'h30C0FF;
         L_RING:       rgb_sel = 24'hFFFFFF;
         L_GOOD:       rgb_sel = 24'hFFFF00;
         L_BAD:        rgb_sel = 24'hFF00FF;
         L_BLACK:      rgb_sel = 24'h000000;
         L_BAND_START: rgb_sel = 24'h808080;
         L_BAND_WIN:   rgb_sel = 24'h00C000;
         L_BAND_LOSE:  rgb_sel = 24'hC00000;
         default:      rgb_sel = 24'h202040;
      endcase
   end

   // Free-running pipeline; reset drops every pixel in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s1_q     <= '0;
         s2_q     <= L_BG;
         o_rgb    <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], i_pix_valid};
         s1_q     <= s1_d;
         s2_q     <= layer;
         o_rgb    <= vld_pipe[STAGES-1] ? rgb_sel : 24'h0;
      end
   end

   assign o_rgb_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_frame_compositor.sv
// Bench for frame_compositor: directed scenarios plus random pixels/game state,
// all checked against a rectangle-level reference model and a 3-deep queue.
module tb_frame_compositor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_frame_start, i_pix_valid;
  logic [10:0] i_pix_x;
  logic [9:0]  i_pix_y;
  logic [1:0]  i_state;
  logic [10:0] i_player_x, i_enemy_x, i_goodbullet_x, i_badbullet_x;
  logic [9:0]  i_player_y, i_enemy_y, i_goodbullet_y, i_badbullet_y;
  logic [1:0]  i_player_hp, i_enemy_hp;
  logic        i_player_shield, i_enemy_shield, i_player_squat, i_enemy_squat;
  logic        i_goodbullet_isE, i_badbullet_isE;
  logic [23:0] o_rgb;
  logic        o_rgb_valid;
  logic [7:0]  o_frame_cnt;

  int g_state, g_px, g_py, g_ex, g_ey, g_gx, g_gy, g_bx, g_by;
  int g_php, g_ehp, g_psh, g_esh, g_psq, g_esq, g_ge, g_be;

  assign i_state          = 2'(g_state);
  assign i_player_x       = 11'(g_px);
  assign i_player_y       = 10'(g_py);
  assign i_enemy_x        = 11'(g_ex);
  assign i_enemy_y        = 10'(g_ey);
  assign i_goodbullet_x   = 11'(g_gx);
  assign i_goodbullet_y   = 10'(g_gy);
  assign i_badbullet_x    = 11'(g_bx);
  assign i_badbullet_y    = 10'(g_by);
  assign i_player_hp      = 2'(g_php);
  assign i_enemy_hp       = 2'(g_ehp);
  assign i_player_shield  = g_psh[0];
  assign i_enemy_shield   = g_esh[0];
  assign i_player_squat   = g_psq[0];
  assign i_enemy_squat    = g_esq[0];
  assign i_goodbullet_isE = g_ge[0];
  assign i_badbullet_isE  = g_be[0];

  frame_compositor dut (
    .clk(clk), .rst_n(rst_n), .i_frame_start(i_frame_start), .i_pix_valid(i_pix_valid),
    .i_pix_x(i_pix_x), .i_pix_y(i_pix_y), .i_state(i_state),
    .i_player_x(i_player_x), .i_enemy_x(i_enemy_x), .i_goodbullet_x(i_goodbullet_x),
    .i_badbullet_x(i_badbullet_x), .i_player_y(i_player_y), .i_enemy_y(i_enemy_y),
    .i_goodbullet_y(i_goodbullet_y), .i_badbullet_y(i_badbullet_y),
    .i_player_hp(i_player_hp), .i_enemy_hp(i_enemy_hp),
    .i_player_shield(i_player_shield), .i_enemy_shield(i_enemy_shield),
    .i_player_squat(i_player_squat), .i_enemy_squat(i_enemy_squat),
    .i_goodbullet_isE(i_goodbullet_isE), .i_badbullet_isE(i_badbullet_isE),
    .o_rgb(o_rgb), .o_rgb_valid(o_rgb_valid), .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int state, px, py, ex, ey, gx, gy, bx, by, php, ehp, psh, esh, psq, esq, ge, be;
  } snap_t;
  typedef struct { int v; int rgb; } exp_t;

  snap_t m;          // model snapshot
  int    mfc;        // model frame counter
  exp_t  q[$];       // pixels in flight, oldest first
  int    checks = 0;
  int    errors = 0;
  int    last_rgb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic snap_t rst_snap();
    snap_t s;
    s = '{default: 0};
    s.php = 3;
    s.ehp = 3;
    return s;
  endfunction

  function automatic snap_t cur_snap();
    snap_t s;
    s = '{g_state, g_px, g_py, g_ex, g_ey, g_gx, g_gy, g_bx, g_by,
          g_php, g_ehp, g_psh, g_esh, g_psq, g_esq, g_ge, g_be};
    return s;
  endfunction

  function automatic bit in_rect(int x, int y, int ox, int oy, int w, int h);
    return (x >= ox) && (x < ox + w) && (y >= oy) && (y < oy + h);
  endfunction

  // Reference picture: state banner, or layered rectangles in priority order
  function automatic int ref_rgb(snap_t s, int fc, int x, int y);
    bit band  = (y >= 200) && (y <= 279);
    bit blink = ((fc >> 3) & 1) == 1;
    case (s.state)
      0: return band ? 'h808080 : 0;
      2: return band ? 'h00C000 : 0;
      3: return band ? 'hC00000 : 0;
      default: ;
    endcase
    if (s.be != 0 && in_rect(x, y, s.bx, s.by, 16, 16)) return 'hFF00FF;
    if (s.ge != 0 && in_rect(x, y, s.gx, s.gy, 16, 16)) return 'hFFFF00;
    if (s.psh != 0 && blink && in_rect(x, y, s.px - 2, s.py - 2, 68, 100) &&
        !in_rect(x, y, s.px, s.py, 64, 96)) return 'hFFFFFF;
    if (s.psq != 0 ? in_rect(x, y, s.px, s.py + 48, 64, 48) : in_rect(x, y, s.px, s.py, 64, 96))
      return 'h30C0FF;
    if (s.esh != 0 && blink && in_rect(x, y, s.ex - 2, s.ey - 2, 68, 100) &&
        !in_rect(x, y, s.ex, s.ey, 64, 96)) return 'hFFFFFF;
    if (s.esq != 0 ? in_rect(x, y, s.ex, s.ey + 48, 64, 48) : in_rect(x, y, s.ex, s.ey, 64, 96))
      return 'hFF6030;
    for (int i = 0; i < s.php; i++)
      if (in_rect(x, y, 8 + 48 * i, 8, 24, 24)) return 'hE00000;
    for (int i = 0; i < s.ehp; i++)
      if (in_rect(639 - x, y, 8 + 48 * i, 8, 24, 24)) return 'hE00000;
    return 'h202040;
  endfunction

  // One clock: drive at negedge, predict, then compare the pixel issued 3 cycles ago
  task automatic cyc(input bit fs, input bit v, input int x, input int y);
    exp_t e;
    i_frame_start = fs;
    i_pix_valid   = v;
    i_pix_x       = 11'(x);
    i_pix_y       = 10'(y);
    e.v   = v;
    e.rgb = v ? ref_rgb(m, mfc, x, y) : 0;
    q.push_back(e);
    if (fs) begin
      m   = cur_snap();
      mfc = (mfc + 1) % 256;
    end
    @(posedge clk);
    @(negedge clk);
    chk("fcnt", o_frame_cnt, mfc);
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("vld", o_rgb_valid, e.v);
      chk("rgb", o_rgb, e.rgb);
      if (e.v != 0) last_rgb = o_rgb;
    end
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic pix_lit(input string tag, input bit fs, input int x, input int y, input int exp);
    last_rgb = 'hDEADBEEF;
    cyc(fs, 1, x, y);
    flush(3);
    chk(tag, last_rgb, exp);
  endtask

  task automatic rand_state();
    g_state = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 1;
    g_px = int'($urandom_range(0, 740)) - 80;  g_py = int'($urandom_range(0, 600)) - 100;
    g_ex = int'($urandom_range(0, 740)) - 80;  g_ey = int'($urandom_range(0, 600)) - 100;
    g_gx = int'($urandom_range(0, 740)) - 80;  g_gy = int'($urandom_range(0, 600)) - 100;
    g_bx = int'($urandom_range(0, 740)) - 80;  g_by = int'($urandom_range(0, 600)) - 100;
    g_php = int'($urandom_range(0, 3));  g_ehp = int'($urandom_range(0, 3));
    g_psh = int'($urandom_range(0, 1));  g_esh = int'($urandom_range(0, 1));
    g_psq = int'($urandom_range(0, 1));  g_esq = int'($urandom_range(0, 1));
    g_ge  = int'($urandom_range(0, 1));  g_be  = int'($urandom_range(0, 1));
  endtask

  // Pixel biased toward an object edge of the current snapshot
  task automatic rand_pix(output int x, output int y);
    int k = int'($urandom_range(0, 5));
    int ox, oy, w, h;
    case (k)
      0: begin ox = m.px; oy = m.py; w = 64; h = 96; end
      1: begin ox = m.ex; oy = m.ey; w = 64; h = 96; end
      2: begin ox = m.gx; oy = m.gy; w = 16; h = 16; end
      3: begin ox = m.bx; oy = m.by; w = 16; h = 16; end
      4: begin ox = 0; oy = 0; w = 640; h = 40; end
      default: begin ox = 0; oy = 0; w = 700; h = 520; end
    endcase
    x = ox + int'($urandom_range(0, w + 8)) - 4;
    y = oy + int'($urandom_range(0, h + 8)) - 4;
    if (x < 0) x = 0;
    if (x > 700) x = 700;
    if (y < 0) y = 0;
    if (y > 520) y = 520;
  endtask

  initial begin
    int x, y;
    {g_state, g_px, g_py, g_ex, g_ey, g_gx, g_gy, g_bx, g_by} = '0;
    {g_php, g_ehp, g_psh, g_esh, g_psq, g_esq, g_ge, g_be} = '0;
    i_frame_start = 0; i_pix_valid = 0; i_pix_x = '0; i_pix_y = '0;
    m = rst_snap(); mfc = 0; last_rgb = 0;
    #12;
    chk("rst_rgb", o_rgb, 0);
    chk("rst_vld", o_rgb_valid, 0);
    chk("rst_fcnt", o_frame_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    pix_lit("start_band", 0, 320, 240, 'h808080);

    g_state = 1; g_px = 100; g_py = 200; g_ex = 400; g_ey = 300;
    cyc(1, 0, 0, 0);
    pix_lit("ply_hit", 0, 100, 200, 'h30C0FF);
    pix_lit("ply_left", 0, 99, 200, 'h202040);

    g_px = -10; g_py = 50;
    pix_lit("clip_in", 1, 0, 0, 'h000000 + ref_rgb(m, mfc, 0, 0)); // frame start, pixel under old snapshot
    pix_lit("clip_hit", 0, 0, 50, 'h30C0FF);
    pix_lit("clip_out", 0, 54, 50, 'h202040);

    g_px = 100; g_py = 200; g_psq = 1;
    cyc(1, 0, 0, 0);
    pix_lit("squat_top", 0, 100, 247, 'h202040);
    pix_lit("squat_bot", 0, 100, 248, 'h30C0FF);

    g_psq = 0; g_gx = 110; g_gy = 210; g_bx = 110; g_by = 210; g_ge = 1; g_be = 1;
    cyc(1, 0, 0, 0);
    pix_lit("bad_top", 0, 115, 215, 'hFF00FF);
    g_be = 0;
    cyc(1, 0, 0, 0);
    pix_lit("good_top", 0, 115, 215, 'hFFFF00);

    g_px = 300;
    pix_lit("no_fs_hold", 0, 100, 200, 'h30C0FF);
    pix_lit("fs_old_snap", 1, 100, 200, 'h30C0FF);
    pix_lit("fs_new_snap", 0, 100, 200, 'h202040);

    g_state = 3;
    cyc(1, 0, 0, 0);
    pix_lit("lose_band", 0, 320, 240, 'hC00000);
    pix_lit("lose_top", 0, 320, 100, 'h000000);

    g_state = 1; g_php = 2;
    cyc(1, 0, 0, 0);
    pix_lit("hp_box0", 0, 8, 8, 'hE00000);
    pix_lit("hp_box1", 0, 56, 8, 'hE00000);
    pix_lit("hp_none", 0, 104, 8, 'h202040);
    pix_lit("hp_enemy0", 0, 631, 8, 'h202040);

    g_psh = 1;
    cyc(1, 0, 0, 0);
    while (((mfc >> 3) & 1) == 0) cyc(1, 0, 0, 0);
    pix_lit("ring_on", 0, 298, 200, 'hFFFFFF);
    pix_lit("ring_inner", 0, 300, 200, 'h30C0FF);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0) rand_state();
      rand_pix(x, y);
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 7) != 0, x, y);
    end

    // reset while pixels are in flight
    cyc(0, 1, 10, 10);
    cyc(0, 1, 20, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vld", o_rgb_valid, 0);
    chk("mrst_rgb", o_rgb, 0);
    chk("mrst_fcnt", o_frame_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m = rst_snap(); mfc = 0;
    pix_lit("mrst_band", 0, 320, 240, 'h808080);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_compositor.md
Name: frame_compositor

Overview:
- Consumer end of the game-state interface: takes the live game state (FSM state, player/enemy pose, HP, bullets) and the VGA pixel-scan stream, and produces one 24-bit RGB value per scanned pixel.
- Snapshots the game state once per frame, so the picture never tears mid-frame.
- Resolves sprite layering in a fixed 3-stage pipeline.
- Sits between the game controller and the VGA timing/output block.

Parameters:
- SPR_W, 64, player/enemy sprite width in pixels
- SPR_H, 96, player/enemy sprite height in pixels (squat draws the lower SPR_H/2 only)
- BUL_SZ, 16, bullet square side in pixels
- HP_BOX, 24, side of one HP box; boxes are spaced 2*HP_BOX apart, with the top-left corner at (8,8)
- BLINK_BIT, 3, frame-counter bit that gates the shield outline blink

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_frame_start  in  1  one-cycle pulse at the start of vertical blank
- i_pix_valid  in  1  pixel request valid
- i_pix_x  in  11  unsigned scan x, 0..639
- i_pix_y  in  10  unsigned scan y, 0..479
- i_state  in  2  00 START, 01 PLAY, 10 WIN, 11 LOSE
- i_player_x / i_enemy_x / i_goodbullet_x / i_badbullet_x  in  11  signed top-left x
- i_player_y / i_enemy_y / i_goodbullet_y / i_badbullet_y  in  10  signed top-left y
- i_player_hp / i_enemy_hp  in  2  hit points, 0..3
- i_player_shield / i_enemy_shield / i_player_squat / i_enemy_squat  in  1  pose flags
- i_goodbullet_isE / i_badbullet_isE  in  1  bullet exists
- o_rgb  out  24  pixel colour {R,G,B}
- o_rgb_valid  out  1  o_rgb corresponds to the pixel issued 3 cycles earlier
- o_frame_cnt  out  8  frames since reset, wraps 255->0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - o_rgb=0, o_rgb_valid=0, o_frame_cnt=0.
  - All pipeline valids cleared.
  - Snapshot is set to state=START, HP=3/3, both bullets absent, all flags 0, all positions 0.
- Snapshot:
  - Every i_* game input is registered on the edge where i_frame_start=1.
  - A pixel accepted in that same cycle uses the old snapshot; pixels from the next cycle on use the new one.
  - o_frame_cnt increments on the same edge.
- Pipeline (a stage advances every cycle; there is no backpressure):
  - S1 registers pix_x/pix_y/valid. For each object it computes dx=pix-objx and dy=pix-objy in 12-bit signed arithmetic, then registers the hit flags.
  - Hit rule: 0<=dx<W and 0<=dy<H, with a signed compare. Negative or partially off-screen positions therefore clip correctly with no wrap.
  - Squat: hit requires dy>=SPR_H/2.
  - Shield outline: a 2-pixel ring just outside the sprite box (-2<=dx<W+2 and -2<=dy<H+2, excluding the box itself). It is drawn only when shield=1 and o_frame_cnt[BLINK_BIT]=1.
  - S2 selects the layer in priority order, highest first:
    1. bad bullet
    2. good bullet
    3. player shield ring
    4. player
    5. enemy shield ring
    6. enemy
    7. HP boxes
    8. background
  - S3 maps the selected layer to RGB and drives o_rgb/o_rgb_valid.
  - Latency is exactly 3 cycles: i_pix_valid at cycle N gives o_rgb_valid at N+3.
  - When o_rgb_valid=0, o_rgb=0.
- Bullets: drawn only if the corresponding isE=1 in the snapshot.
- HP boxes:
  - Player boxes i=0..hp-1 sit at x=8+2*HP_BOX*i, y=8.
  - Enemy boxes mirror from x=631 leftward.
  - hp=0 draws no boxes.
- Colours:
  - background 0x202040, player 0x30C0FF, enemy 0xFF6030
  - good bullet 0xFFFF00, bad bullet 0xFF00FF
  - shield ring 0xFFFFFF, HP box 0xE00000
- Non-PLAY states (sprites suppressed; only background and banner colours):
  - START: whole screen 0x000000, except a centre band (y 200..279) of 0x808080.
  - WIN: the band is 0x00C000.
  - LOSE: the band is 0xC00000.
- Pixels with x>=640 or y>=480 are still processed, and they follow the same colour rules.
- Simultaneous i_frame_start and pixel valid: both are serviced. Pixels already in flight keep the layer decision computed under the snapshot they entered with.
- Reset asserted mid-frame: the pipeline empties immediately, and the output is valid again only 3 cycles after new pixel requests.

Test Plan:
- Reset, then one i_frame_start with state=PLAY, player at (100,200), other objects absent, and pixel (100,200) → 3 cycles later o_rgb=0x30C0FF, o_rgb_valid=1. Pixel (99,200) → 0x202040.
- Player at (-10,50), pixel (0,50) → 0x30C0FF. Pixel (54,50) → background (dx=64 is out).
- Player squat=1 at (100,200): pixel (100,247) → background; pixel (100,248) → player colour.
- Both bullets overlap the player at the same pixel, both isE=1 → 0xFF00FF. Then clear bad isE → 0xFFFF00.
- Change i_player_x while no frame start occurs → output is unchanged. Apply i_frame_start in the same cycle as a pixel → that pixel uses the old position, the next pixel uses the new one.
- state=LOSE → pixel (320,240) gives 0xC00000 and (320,100) gives 0x000000. player_hp=2, PLAY → pixels (8,8) and (56,8) give 0xE00000, (104,8) gives background.
